memory_port_scheduler: RTL and testbench



---
 rtl/memory_port_scheduler_pkg.sv | 31 +++
 rtl/memory_port_scheduler_arbiter.sv | 21 ++
 rtl/memory_port_scheduler.sv | 122 ++++++++++++
 tb/tb_memory_port_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_port_scheduler_pkg.sv
// Shared encodings for the cache/main-memory port scheduler: request and status
// codes, scheduler state and grant side.
package memory_port_scheduler_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_req_e;

    typedef enum logic [1:0] {
        MEM_RESTING       = 2'd0,
        MEM_WORKING       = 2'd1,
        MEM_INST_FINISHED = 2'd2,
        MEM_DATA_FINISHED = 2'd3
    } mem_status_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_side_e;

    localparam int MASK_W = 4;

endpackage

// File: rtl/memory_port_scheduler_arbiter.sv
// Two-input round-robin grant: on a tie the side that did not win last time wins.
// Purely combinational; the last-grant history lives in the parent.
module mem_rr_arbiter
    import memory_port_scheduler_pkg::*;
(
    input  logic        i_req,
    input  logic        d_req,
    input  grant_side_e last_grant,
    output logic        grant_vld,
    output grant_side_e grant
);

    always_comb begin
        grant_vld = i_req | d_req;
        grant     = GRANT_INST;
        if (d_req && (!i_req || last_grant == GRANT_INST)) begin
            grant = GRANT_DATA;
        end
    end

endmodule

// File: rtl/memory_port_scheduler.sv
// Shares the single main-memory port between the instruction and data caches:
// round-robin grant, fixed-latency transaction, one-cycle FINISHED status.
module memory_port_scheduler
    import memory_port_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_LEN    = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            i_vis_signal,
    input  logic [ADDR_WIDTH-1:0] i_vis_addr,
    output logic [1:0]            i_mem_status,
    output logic [DATA_LEN-1:0]   i_mem_data,
    input  logic [1:0]            d_vis_signal,
    input  logic [ADDR_WIDTH-1:0] d_vis_addr,
    input  logic [DATA_LEN-1:0]   d_wdata,
    input  logic [MASK_W-1:0]     d_wmask,
    output logic [1:0]            d_mem_status,
    output logic [DATA_LEN-1:0]   d_mem_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_LEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0]     mem_wmask,
    input  logic [DATA_LEN-1:0]   mem_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    sched_state_e          state;
    grant_side_e           last_grant;
    grant_side_e           grant;
    logic                  grant_vld;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_LEN-1:0]   rdata;
    logic                  i_req;
    logic                  d_req;

    assign i_req = (i_vis_signal == MEM_READ);
    assign d_req = (d_vis_signal == MEM_READ) || (d_vis_signal == MEM_WRITE);

    mem_rr_arbiter u_arb (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant_vld  (grant_vld),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_DATA;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            rdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        last_grant <= grant;
                        cnt        <= CNT_INIT;
                        mem_en     <= 1'b1;
                        state      <= ST_BUSY;
                        if (grant == GRANT_DATA) begin
                            mem_addr  <= d_vis_addr;
                            mem_we    <= (d_vis_signal == MEM_WRITE);
                            mem_wdata <= d_wdata;
                            mem_wmask <= d_wmask;
                        end else begin
                            mem_addr  <= i_vis_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    // mem_* stay frozen; the last BUSY cycle sees the synchronous read data
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rdata  <= mem_rdata;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status is a decode of registered state only, so inputs never reach it combinationally.
    always_comb begin
        i_mem_status = MEM_RESTING;
        d_mem_status = MEM_RESTING;
        if (state == ST_BUSY) begin
            if (last_grant == GRANT_DATA) d_mem_status = MEM_WORKING;
            else                          i_mem_status = MEM_WORKING;
        end else if (state == ST_DONE) begin
            if (last_grant == GRANT_DATA) d_mem_status = MEM_DATA_FINISHED;
            else                          i_mem_status = MEM_INST_FINISHED;
        end
    end

    assign i_mem_data = rdata;
    assign d_mem_data = rdata;

endmodule

// File: tb/tb_memory_port_scheduler.sv
// Directed bench for memory_port_scheduler with a synchronous-read memory model
// and a completion scoreboard.
module tb_memory_port_scheduler;
    import memory_port_scheduler_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    i_vis_signal;
    logic [AW-1:0] i_vis_addr;
    logic [1:0]    i_mem_status;
    logic [DW-1:0] i_mem_data;
    logic [1:0]    d_vis_signal;
    logic [AW-1:0] d_vis_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wmask;
    logic [1:0]    d_mem_status;
    logic [DW-1:0] d_mem_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic [DW-1:0] mem_rdata;

    int checks;
    int failures;

    typedef struct {
        logic          side;
        logic          chk_data;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    memory_port_scheduler #(.ADDR_WIDTH(AW), .DATA_LEN(DW), .MEM_LATENCY(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_vis_signal (i_vis_signal),
        .i_vis_addr   (i_vis_addr),
        .i_mem_status (i_mem_status),
        .i_mem_data   (i_mem_data),
        .d_vis_signal (d_vis_signal),
        .d_vis_addr   (d_vis_addr),
        .d_wdata      (d_wdata),
        .d_wmask      (d_wmask),
        .d_mem_status (d_mem_status),
        .d_mem_data   (d_mem_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words read back a per-address seed.
    logic [DW-1:0] wmem [0:1023];
    logic [1023:0] written = '0;

    function automatic logic [DW-1:0] mem_read(input logic [9:0] a);
        if (written[a]) return wmem[a];
        if (a == 10'h010) return 32'hDEADBEEF;
        return {22'h30_37A, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                logic [DW-1:0] w;
                w = mem_read(mem_addr[9:0]);
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                wmem[mem_addr[9:0]]    <= w;
                written[mem_addr[9:0]] <= 1'b1;
            end else begin
                mem_rdata <= mem_read(mem_addr[9:0]);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_vis_signal = MEM_NOP;
        i_vis_addr   = '0;
        d_vis_signal = MEM_NOP;
        d_vis_addr   = '0;
        d_wdata      = '0;
        d_wmask      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    // Completion monitor: every FINISHED pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn && (i_mem_status == MEM_INST_FINISHED || d_mem_status == MEM_DATA_FINISHED)) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $display("FAIL sb_underflow observed i_status=%0d d_status=%0d expected no completion",
                         i_mem_status, d_mem_status);
                $error("unexpected completion");
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.side) begin
                    chk("done_d_status", d_mem_status, MEM_DATA_FINISHED);
                    chk("done_i_quiet", i_mem_status, MEM_RESTING);
                end else begin
                    chk("done_i_status", i_mem_status, MEM_INST_FINISHED);
                    chk("done_d_quiet", d_mem_status, MEM_RESTING);
                end
                if (mon_e.chk_data) begin
                    chk("done_i_data", i_mem_data, mon_e.data);
                    chk("done_d_data", d_mem_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        do_reset();

        chk("rst_en", mem_en, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wmask", mem_wmask, 0);
        chk("rst_i_status", i_mem_status, MEM_RESTING);
        chk("rst_d_status", d_mem_status, MEM_RESTING);
        chk("rst_rdata", i_mem_data, 0);

        // Single instruction read
        i_vis_signal = MEM_READ;
        i_vis_addr   = 20'h00010;
        sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        chk("t1_c0_en", mem_en, 0);
        step();
        chk("t1_c1_en", mem_en, 1);
        chk("t1_c1_addr", mem_addr, 20'h00010);
        chk("t1_c1_we", mem_we, 0);
        chk("t1_c1_i", i_mem_status, MEM_WORKING);
        chk("t1_c1_d", d_mem_status, MEM_RESTING);
        step();
        chk("t1_c2_en", mem_en, 1);
        chk("t1_c2_i", i_mem_status, MEM_WORKING);
        step();
        chk("t1_c3_i", i_mem_status, MEM_INST_FINISHED);
        chk("t1_c3_data", i_mem_data, 32'hDEADBEEF);
        chk("t1_c3_en", mem_en, 0);
        i_vis_signal = MEM_NOP;
        step();
        chk("t1_c4_i", i_mem_status, MEM_RESTING);
        chk("t1_c4_en", mem_en, 0);

        // Simultaneous requests right after reset: instruction first
        do_reset();
        i_vis_signal = MEM_READ;  i_vis_addr = 20'h00020;
        d_vis_signal = MEM_READ;  d_vis_addr = 20'h00030;
        sb.push_back('{1'b0, 1'b1, mem_read(10'h020)});
        sb.push_back('{1'b1, 1'b1, mem_read(10'h030)});
        step();
        chk("t2_c1_addr", mem_addr, 20'h00020);
        chk("t2_c1_d", d_mem_status, MEM_RESTING);
        step();
        chk("t2_c2_d", d_mem_status, MEM_RESTING);
        step();
        i_vis_signal = MEM_NOP;
        step();
        chk("t2_c4_en", mem_en, 0);
        chk("t2_c4_d", d_mem_status, MEM_RESTING);
        step();
        chk("t2_c5_addr", mem_addr, 20'h00030);
        chk("t2_c5_d", d_mem_status, MEM_WORKING);
        chk("t2_c5_i", i_mem_status, MEM_RESTING);
        step();
        step();
        d_vis_signal = MEM_NOP;
        step();

        // Both sides held for four transactions: I,D,I,D
        i_vis_signal = MEM_READ;  i_vis_addr = 20'h00040;
        d_vis_signal = MEM_READ;  d_vis_addr = 20'h00050;
        for (int t = 0; t < 4; t++)
            sb.push_back('{t[0], 1'b1, mem_read(t[0] ? 10'h050 : 10'h040)});
        for (int t = 0; t < 4; t++) begin
            logic [AW-1:0] ea;
            ea = t[0] ? 20'h00050 : 20'h00040;
            chk("t3_idle_en", mem_en, 0);
            step();
            chk("t3_b1_en", mem_en, 1);
            chk("t3_b1_addr", mem_addr, ea);
            chk("t3_b1_status", t[0] ? d_mem_status : i_mem_status, MEM_WORKING);
            step();
            chk("t3_b2_addr", mem_addr, ea);
            step();
            chk("t3_done_addr", mem_addr, ea);
            step();
            chk("t3_next_idle_addr", mem_addr, ea);
        end
        i_vis_signal = MEM_NOP;
        d_vis_signal = MEM_NOP;
        step();

        // Data write then read-back of the same word
        d_vis_signal = MEM_WRITE;  d_vis_addr = 20'h00100;
        d_wdata = 32'h12345678;    d_wmask = 4'b1111;
        sb.push_back('{1'b1, 1'b0, 32'h0});
        step();
        chk("t4_w1_we", mem_we, 1);
        chk("t4_w1_wdata", mem_wdata, 32'h12345678);
        chk("t4_w1_wmask", mem_wmask, 4'b1111);
        chk("t4_w1_addr", mem_addr, 20'h00100);
        step();
        chk("t4_w2_we", mem_we, 1);
        step();
        chk("t4_wdone_we", mem_we, 0);
        chk("t4_wdone_d", d_mem_status, MEM_DATA_FINISHED);
        d_vis_signal = MEM_READ;
        sb.push_back('{1'b1, 1'b1, 32'h12345678});
        step();
        chk("t4_idle_we", mem_we, 0);
        step();
        chk("t4_r1_en", mem_en, 1);
        chk("t4_r1_we", mem_we, 0);
        step();
        step();
        chk("t4_rdone_data", d_mem_data, 32'h12345678);
        d_vis_signal = MEM_NOP;
        step();

        // Asynchronous reset during a data write
        d_vis_signal = MEM_WRITE;  d_vis_addr = 20'h00200;
        d_wdata = 32'hAAAA5555;    d_wmask = 4'b0011;
        step();
        chk("t5_b1_we", mem_we, 1);
        i_vis_signal = MEM_READ;  i_vis_addr = 20'h00060;
        #1 rstn = 1'b0;
        #1;
        chk("t5_rst_en", mem_en, 0);
        chk("t5_rst_we", mem_we, 0);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_d", d_mem_status, MEM_RESTING);
        chk("t5_rst_i", i_mem_status, MEM_RESTING);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        sb.push_back('{1'b0, 1'b1, mem_read(10'h060)});
        sb.push_back('{1'b1, 1'b0, 32'h0});
        step();
        chk("t5_first_addr", mem_addr, 20'h00060);
        chk("t5_first_i", i_mem_status, MEM_WORKING);
        chk("t5_first_d", d_mem_status, MEM_RESTING);
        step();
        step();
        i_vis_signal = MEM_NOP;
        step();
        step();
        chk("t5_second_addr", mem_addr, 20'h00200);
        chk("t5_second_we", mem_we, 1);
        chk("t5_second_d", d_mem_status, MEM_WORKING);
        step();
        step();
        d_vis_signal = MEM_NOP;
        step();

        // Invalid instruction code and data NOP: no grant
        i_vis_signal = 2'b11;
        d_vis_signal = MEM_NOP;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t6_en", mem_en, 0);
            chk("t6_i", i_mem_status, MEM_RESTING);
            chk("t6_d", d_mem_status, MEM_RESTING);
        end
        i_vis_signal = MEM_NOP;
        step();

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
